// File: rtl/enc_controller_pkg.sv
// Shared constants and types for the RS encoder input controller.
// Symbol geometry, codeword length, FIFO sizing and the controller state type.
package enc_controller_pkg;

  localparam int EGF_ORDER      = 8;
  localparam int ENC_SYM_NUM    = 4;
  localparam int RS_MES_LEN     = 239;
  localparam int RS_COD_LEN     = 255;
  localparam int CON_FIFO_DEPTH = 4;
  localparam int CON_START_LVL  = 2;

  localparam int DATA_W = EGF_ORDER * ENC_SYM_NUM;
  localparam int CNT_W  = $clog2(RS_COD_LEN);
  localparam int LVL_W  = $clog2(CON_FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(CON_FIFO_DEPTH);

  typedef enum logic {
    CON_IDLE = 1'b0,
    CON_RUN  = 1'b1
  } con_state_t;

endpackage

// File: rtl/enc_controller_fifo.sv
// Small symbol FIFO feeding the encoder; head is zero whenever it is empty.
// Storage is not reset, only pointers and occupancy.
module enc_sym_fifo
  import enc_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] data,
  output logic [LVL_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [CON_FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == LVL_W'(CON_FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign data    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

endmodule

// File: rtl/enc_controller.sv
// Encoder input controller: buffers source beats and sequences codeword phase.
// Handshake: a beat transfers on any rising edge where in_valid && in_ready.
module enc_controller
  import enc_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              buf_enable,
  output logic [CNT_W-1:0]  con_master_counter,
  output logic [DATA_W-1:0] enc_data,
  output logic              con_busy,
  output logic              con_cw_start,
  output logic              con_cw_end,
  output logic              con_underflow,
  output logic              con_state_dbg
);

  con_state_t       state;
  logic [LVL_W-1:0] count;
  logic             full;
  logic             empty;
  logic             pop;
  logic             start_ok;

  assign in_ready = !full;
  assign pop      = (state == CON_RUN) && buf_enable && !empty;
  assign start_ok = (count >= LVL_W'(CON_START_LVL));

  enc_sym_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_valid),
    .wr_data (in_data),
    .pop     (pop),
    .data    (enc_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // The buffer cannot stall, so the counter free-runs in RUN even when starved.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= CON_IDLE;
      con_master_counter <= '0;
      con_underflow      <= 1'b0;
    end else begin
      if ((state == CON_RUN) && buf_enable && empty) begin
        con_underflow <= 1'b1;
      end
      case (state)
        CON_IDLE: begin
          if (start_ok) begin
            state              <= CON_RUN;
            con_master_counter <= CNT_W'(1);
          end else begin
            con_master_counter <= '0;
          end
        end
        CON_RUN: begin
          if (con_master_counter == CNT_W'(RS_COD_LEN)) begin
            if (start_ok) begin
              con_master_counter <= CNT_W'(1);
            end else begin
              con_master_counter <= '0;
              state              <= CON_IDLE;
            end
          end else begin
            con_master_counter <= con_master_counter + CNT_W'(1);
          end
        end
        default: begin
          state              <= CON_IDLE;
          con_master_counter <= '0;
        end
      endcase
    end
  end

  assign con_busy      = (state == CON_RUN);
  assign con_cw_start  = (con_master_counter == CNT_W'(1));
  assign con_cw_end    = (con_master_counter == CNT_W'(RS_COD_LEN));
  assign con_state_dbg = state;

endmodule

// File: tb/tb_enc_controller.sv
// Randomized bench for enc_controller against a queue-based reference model.
module tb_enc_controller;
  import enc_controller_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              buf_enable;
  logic [CNT_W-1:0]  con_master_counter;
  logic [DATA_W-1:0] enc_data;
  logic              con_busy;
  logic              con_cw_start;
  logic              con_cw_end;
  logic              con_underflow;
  logic              con_state_dbg;

  enc_controller dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .buf_enable         (buf_enable),
    .con_master_counter (con_master_counter),
    .enc_data           (enc_data),
    .con_busy           (con_busy),
    .con_cw_start       (con_cw_start),
    .con_cw_end         (con_cw_end),
    .con_underflow      (con_underflow),
    .con_state_dbg      (con_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: beats held in a queue, codeword phase as a plain integer
  logic [DATA_W-1:0] exp_q[$];
  int                m_phase;
  bit                m_uf;
  bit                hold;
  int                n_checks;
  int                n_errors;
  int                n_wraps_b2b;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("counter",   DATA_W'(con_master_counter), DATA_W'(m_phase));
    chk("in_ready",  DATA_W'(in_ready),           DATA_W'(exp_q.size() < CON_FIFO_DEPTH));
    chk("enc_data",  enc_data,                    (exp_q.size() > 0) ? exp_q[0] : '0);
    chk("busy",      DATA_W'(con_busy),           DATA_W'(m_phase != 0));
    chk("cw_start",  DATA_W'(con_cw_start),       DATA_W'(m_phase == 1));
    chk("cw_end",    DATA_W'(con_cw_end),         DATA_W'(m_phase == RS_COD_LEN));
    chk("underflow", DATA_W'(con_underflow),      DATA_W'(m_uf));
  endtask

  task automatic model_step();
    bit running;
    bit accept;
    bit enough;
    if (!rst_n) begin
      exp_q.delete();
      m_phase = 0;
      m_uf    = 1'b0;
      hold    = 1'b0;
      return;
    end
    running = (m_phase != 0);
    accept  = in_valid && (exp_q.size() < CON_FIFO_DEPTH);
    enough  = (exp_q.size() >= CON_START_LVL);
    if (running && buf_enable && exp_q.size() == 0) m_uf = 1'b1;
    if (m_phase == 0 || m_phase == RS_COD_LEN) begin
      if (m_phase == RS_COD_LEN && enough) n_wraps_b2b++;
      m_phase = enough ? 1 : 0;
    end else begin
      m_phase = m_phase + 1;
    end
    if (running && buf_enable && exp_q.size() > 0) void'(exp_q.pop_front());
    if (accept) exp_q.push_back(in_data);
    hold = in_valid && !accept;
  endtask

  // driver: one clock cycle with given reset level and valid/enable percentages;
  // a refused beat is held stable by the source until it is accepted
  task automatic do_cycle(input bit rstn, input int vpct, input int bpct);
    rst_n = rstn;
    if (!rstn) begin
      in_valid = 1'b0;
    end else if (!hold) begin
      in_valid = ($urandom_range(99, 0) < vpct);
      in_data  = DATA_W'($urandom);
    end
    buf_enable = ($urandom_range(99, 0) < bpct);
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input int n, input int vpct, input int bpct);
    for (int i = 0; i < n; i++) do_cycle(1'b1, vpct, bpct);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    n_wraps_b2b = 0;
    m_phase     = 0;
    m_uf        = 1'b0;
    hold        = 1'b0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    buf_enable  = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) do_cycle(1'b0, 0, 100);
    // idle after reset: no start even with the buffer enabled
    run(20, 0, 100);
    // two beats back to back, then watch a full codeword drain and end
    run(2, 100, 0);
    run(1, 0, 0);
    chk("first_start", DATA_W'(con_master_counter), DATA_W'(1));
    run(260, 0, 50);
    // heavily fed source: back-to-back codewords, full FIFO backpressure
    run(4, 100, 100);
    run(8, 100, 0);
    chk("full_ready", DATA_W'(in_ready), DATA_W'(0));
    run(300, 100, 40);
    // starve the buffer mid-codeword, then resume
    run(20, 0, 100);
    run(300, 60, 60);
    // reset pulse mid-codeword with a loaded FIFO
    run(40, 100, 30);
    do_cycle(1'b0, 100, 50);
    chk("rst_counter", DATA_W'(con_master_counter), DATA_W'(0));
    chk("rst_ready",   DATA_W'(in_ready),           DATA_W'(1));
    chk("rst_uf",      DATA_W'(con_underflow),      DATA_W'(0));
    run(600, 70, 70);
    chk("saw_b2b_wrap", DATA_W'(n_wraps_b2b > 0), DATA_W'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
